uc_seq_stack: RTL and testbench
===============================

// Module: uc_seq_stack
// PURPOSE
//  Sequential, parametrised control unit for the CPU datapath. Replaces the purely
//  combinational decoder with a small FSM that issues registered one-cycle control strobes.
//  Tracks a hardware return stack (CALL/RET) with a depth counter and full/empty/error flags.
//  Adds a HALT instruction. Sits between the instruction memory, the PC mux/stack and the
//  register file/ALU.
// PARAMETERS
//  OPW   6   opcode width (>=6); class bit = opcode[OPW-1]
//  ALUW  3   ALU op field width; field = opcode[OPW-2 -: ALUW]
//  DEPTH 16  return-stack entries (>=1); SPW = $clog2(DEPTH+1)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous reset, active-low
//  opcode       in   OPW    instruction opcode from instruction memory
//  z            in   1      zero flag from datapath flag register
//  instr_valid  in   1      opcode valid this cycle
//  err_clr      in   1      clears stack error state
//  s_inc        out  1      PC mux: 1 = PC+1, 0 = jump target
//  s_inm        out  1      regfile write-data mux: 1 = immediate
//  we3          out  1      regfile write enable
//  wez          out  1      zero-flag write enable
//  s_pila       out  1      PC mux: 1 = stack top
//  push         out  1      stack push strobe
//  pop          out  1      stack pop strobe
//  op_alu       out  ALUW   ALU operation
//  pc_en        out  1      PC load enable; exactly one pulse per completed instruction
//  sp           out  SPW    stack occupancy, 0..DEPTH
//  stk_full     out  1      sp == DEPTH
//  stk_empty    out  1      sp == 0
//  stk_err      out  1      sticky overflow/underflow flag
//  halted       out  1      HALT executed
// BEHAVIOUR
//  - Reset (reset=0, async): state=FETCH; s_inc=1; all other outputs 0; sp=0; stk_empty=1.
//  - All outputs are registered. Strobes (we3, wez, s_inm, push, pop, pc_en) are 1-cycle pulses.
//    Selects idle at s_inc=1, s_pila=0. op_alu holds its last value.
//  - FETCH: waits for instr_valid=1, latches opcode, goes to EXEC. No strobes.
//  - EXEC (1 cycle; z sampled this cycle). Decode of the latched opcode:
//    0xx..x arith : op_alu=field, we3=1, wez=1, s_inm=0, pc_en=1
//    10..000 ldi  : s_inm=1, we3=1, pc_en=1
//    10..001 jmp  : s_inc=0, pc_en=1
//    10..010 jz   : s_inc=~z, pc_en=1
//    10..011 jnz  : s_inc=z, pc_en=1
//    10..100 call : sp<DEPTH -> push=1, s_inc=0, pc_en=1, sp+1
//                   sp==DEPTH -> ERROR, stk_err=1, no push, no pc_en
//    10..101 ret  : sp>0 -> pop=1, sp-1, go to POP2
//                   sp==0 -> ERROR, stk_err=1
//    1..1 (all ones) halt : halted=1, go to HALT, no pc_en
//    any other    : NOP, pc_en=1
//    Middle bits "..." are zeros for OPW>6. Success returns to FETCH.
//  - POP2: s_pila=1, pc_en=1, then FETCH. s_pila returns to 0 the following cycle.
//  - ERROR: holds, outputs idle, sp unchanged. err_clr=1 -> stk_err=0, FETCH next cycle.
//  - HALT: absorbing; ignores instr_valid and err_clr; exits only by reset.
//  - instr_valid is ignored outside FETCH. CPI: 2 cycles (ret: 3 cycles).
//  - stk_full/stk_empty are decoded from the registered sp and update with it.
//    sp never wraps and saturates at 0..DEPTH.
//  - Reset asserted mid-instruction aborts it; no partial strobe survives.
// TESTING
//  1 reset, then arith opcode 0_011_00 -> EXEC cycle: op_alu=3'b011, we3=wez=pc_en=1, s_inm=0
//  2 jz with z=1 -> s_inc=0, pc_en=1; jz with z=0 -> s_inc=1; jnz mirrored
//  3 DEPTH=4: 4 calls -> sp=4, stk_full=1; 5th call -> stk_err=1, push=0, pc_en=0, sp=4;
//    err_clr -> FETCH
//  4 call then ret -> push; pop then s_pila=1 + pc_en in POP2; sp 1->0; stk_empty=1;
//    ret at sp=0 -> stk_err
//  5 halt 6'b111111 -> halted=1, then no strobes for 20 cycles despite instr_valid;
//    reset -> halted=0
//  6 reset asserted during POP2 -> outputs immediately at reset values, sp=0

Source files
------------

// File: rtl/uc_seq_stack.sv
// Sequential control unit: FETCH/EXEC FSM with registered one-cycle strobes,
// a hardware return-stack depth tracker with full/empty/sticky-error flags, and HALT.
module uc_seq_stack #(
   parameter int OPW   = 6,
   parameter int ALUW  = 3,
   parameter int DEPTH = 16,
   localparam int SPW  = $clog2(DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OPW-1:0]  opcode,
   input  logic            z,
   input  logic            instr_valid,
   input  logic            err_clr,
   output logic            s_inc,
   output logic            s_inm,
   output logic            we3,
   output logic            wez,
   output logic            s_pila,
   output logic            push,
   output logic            pop,
   output logic [ALUW-1:0] op_alu,
   output logic            pc_en,
   output logic [SPW-1:0]  sp,
   output logic            stk_full,
   output logic            stk_empty,
   output logic            stk_err,
   output logic            halted,
   output logic [2:0]      dbg_state
);

   typedef enum logic [2:0] {
      S_FETCH = 3'd0,
      S_EXEC  = 3'd1,
      S_POP2  = 3'd2,
      S_ERROR = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [OPW-1:0]  opc_q, opc_d;
   logic            s_inc_q, s_inc_d, s_inm_q, s_inm_d, we3_q, we3_d, wez_q, wez_d;
   logic            s_pila_q, s_pila_d, push_q, push_d, pop_q, pop_d, pc_en_q, pc_en_d;
   logic [ALUW-1:0] op_alu_q, op_alu_d;
   logic [SPW-1:0]  sp_q, sp_d;
   logic            err_q, err_d, halted_q, halted_d;

   logic            is_arith, is_halt, mid_zero, sp_full;
   logic [2:0]      fn;

   assign is_arith = ~opc_q[OPW-1];
   assign is_halt  = &opc_q;
   assign mid_zero = (opc_q[OPW-2:3] == '0);
   assign fn       = opc_q[2:0];
   assign sp_full  = (sp_q == SPW'(DEPTH));

   // Handshake: an opcode is accepted only in FETCH on a cycle with instr_valid=1;
   // there is no ready, so the source must hold opcode/instr_valid until the FSM is back in FETCH.
   always_comb begin
      state_d  = state_q;
      opc_d    = opc_q;
      s_inc_d  = 1'b1;
      s_inm_d  = 1'b0;
      we3_d    = 1'b0;
      wez_d    = 1'b0;
      s_pila_d = 1'b0;
      push_d   = 1'b0;
      pop_d    = 1'b0;
      pc_en_d  = 1'b0;
      op_alu_d = op_alu_q;
      sp_d     = sp_q;
      err_d    = err_q;
      halted_d = halted_q;
      case (state_q)
         S_FETCH: begin
            if (instr_valid) begin
               opc_d   = opcode;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            state_d = S_FETCH;
            if (is_arith) begin
               op_alu_d = opc_q[OPW-2 -: ALUW];
               we3_d    = 1'b1;
               wez_d    = 1'b1;
               pc_en_d  = 1'b1;
            end else if (is_halt) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else if (!mid_zero) begin
               pc_en_d = 1'b1;
            end else begin
               case (fn)
                  3'b000: begin s_inm_d = 1'b1; we3_d = 1'b1; pc_en_d = 1'b1; end
                  3'b001: begin s_inc_d = 1'b0; pc_en_d = 1'b1; end
                  3'b010: begin s_inc_d = ~z;   pc_en_d = 1'b1; end
                  3'b011: begin s_inc_d = z;    pc_en_d = 1'b1; end
                  3'b100: begin
                     if (!sp_full) begin
                        push_d  = 1'b1;
                        s_inc_d = 1'b0;
                        pc_en_d = 1'b1;
                        sp_d    = sp_q + SPW'(1);
                     end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                     end
                  end
                  3'b101: begin
                     if (sp_q != '0) begin
                        pop_d   = 1'b1;
                        sp_d    = sp_q - SPW'(1);
                        state_d = S_POP2;
                     end else begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                     end
                  end
                  default: pc_en_d = 1'b1;
               endcase
            end
         end
         S_POP2: begin
            s_pila_d = 1'b1;
            pc_en_d  = 1'b1;
            state_d  = S_FETCH;
         end
         S_ERROR: begin
            if (err_clr) begin
               err_d   = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_FETCH;
         opc_q    <= '0;
         s_inc_q  <= 1'b1;
         s_inm_q  <= 1'b0;
         we3_q    <= 1'b0;
         wez_q    <= 1'b0;
         s_pila_q <= 1'b0;
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
         pc_en_q  <= 1'b0;
         op_alu_q <= '0;
         sp_q     <= '0;
         err_q    <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         opc_q    <= opc_d;
         s_inc_q  <= s_inc_d;
         s_inm_q  <= s_inm_d;
         we3_q    <= we3_d;
         wez_q    <= wez_d;
         s_pila_q <= s_pila_d;
         push_q   <= push_d;
         pop_q    <= pop_d;
         pc_en_q  <= pc_en_d;
         op_alu_q <= op_alu_d;
         sp_q     <= sp_d;
         err_q    <= err_d;
         halted_q <= halted_d;
      end
   end

   assign s_inc     = s_inc_q;
   assign s_inm     = s_inm_q;
   assign we3       = we3_q;
   assign wez       = wez_q;
   assign s_pila    = s_pila_q;
   assign push      = push_q;
   assign pop       = pop_q;
   assign op_alu    = op_alu_q;
   assign pc_en     = pc_en_q;
   assign sp        = sp_q;
   assign stk_full  = sp_full;
   assign stk_empty = (sp_q == '0);
   assign stk_err   = err_q;
   assign halted    = halted_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uc_seq_stack.sv
// Bench for uc_seq_stack (DEPTH=4): decode table, hand-written stack/halt/reset
// sequences, and random instruction streams against an instruction-level model.
module tb_uc_seq_stack;

   localparam int DEPTH = 4;
   localparam int SPW   = 3;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [5:0]     opcode = '0;
   logic           z = 1'b0;
   logic           instr_valid = 1'b0;
   logic           err_clr = 1'b0;
   logic           s_inc, s_inm, we3, wez, s_pila, push, pop, pc_en;
   logic [2:0]     op_alu;
   logic [SPW-1:0] sp;
   logic           stk_full, stk_empty, stk_err, halted;
   logic [2:0]     dbg_state;

   int checks = 0;
   int failures = 0;

   // instruction-level model state
   int         m_sp;
   logic       m_err, m_halt;
   logic [2:0] m_alu;

   typedef struct {
      logic [5:0] op;
      logic       zf;
      logic [9:0] exp;   // {s_inc,s_inm,we3,wez,push,pop,pc_en,op_alu}
   } vec_t;
   vec_t tbl[11];

   localparam logic [17:0] RESET_SNAP = 18'b1_0_0_0_0_0_0_0_000_000_0_1_0_0;

   uc_seq_stack #(.OPW(6), .ALUW(3), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .instr_valid(instr_valid),
      .err_clr(err_clr), .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez),
      .s_pila(s_pila), .push(push), .pop(pop), .op_alu(op_alu), .pc_en(pc_en),
      .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err),
      .halted(halted), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [17:0] obs();
      return {s_inc, s_inm, we3, wez, s_pila, push, pop, pc_en, op_alu, sp,
              stk_full, stk_empty, stk_err, halted};
   endfunction

   function automatic logic [17:0] pack(input logic si, sm, w3, wz, pl, pu, po, pe);
      return {si, sm, w3, wz, pl, pu, po, pe, m_alu, 3'(m_sp),
              m_sp == DEPTH, m_sp == 0, m_err, m_halt};
   endfunction

   task automatic model_reset();
      m_sp = 0; m_err = 1'b0; m_halt = 1'b0; m_alu = '0;
   endtask

   // kind: 0 done, 1 return (extra POP2 cycle), 2 stack error, 3 halt
   task automatic model_exec(input logic [5:0] op, input logic zf,
                             output logic [17:0] e, output int kind);
      logic si, sm, w3, wz, pu, po, pe;
      si = 1'b1; sm = 1'b0; w3 = 1'b0; wz = 1'b0; pu = 1'b0; po = 1'b0; pe = 1'b0;
      kind = 0;
      if (op[5] == 1'b0) begin
         m_alu = op[4:2]; w3 = 1'b1; wz = 1'b1; pe = 1'b1;
      end else if (op == 6'h3F) begin
         m_halt = 1'b1; kind = 3;
      end else if (op[4:3] != 2'b00) begin
         pe = 1'b1;
      end else begin
         case (op[2:0])
            3'd0: begin sm = 1'b1; w3 = 1'b1; pe = 1'b1; end
            3'd1: begin si = 1'b0; pe = 1'b1; end
            3'd2: begin si = !zf; pe = 1'b1; end
            3'd3: begin si = zf; pe = 1'b1; end
            3'd4: if (m_sp < DEPTH) begin pu = 1'b1; si = 1'b0; pe = 1'b1; m_sp++; end
                  else begin m_err = 1'b1; kind = 2; end
            3'd5: if (m_sp > 0) begin po = 1'b1; m_sp--; kind = 1; end
                  else begin m_err = 1'b1; kind = 2; end
            default: pe = 1'b1;
         endcase
      end
      e = pack(si, sm, w3, wz, 1'b0, pu, po, pe);
   endtask

   task automatic do_reset();
      reset = 1'b0; instr_valid = 1'b0; err_clr = 1'b0;
      step(); step();
      reset = 1'b1;
      model_reset();
   endtask

   // FETCH + EXEC, then POP2 or error recovery as the model predicts
   task automatic run_instr(input logic [5:0] op, input logic zf, output int kind);
      logic [17:0] e;
      instr_valid = 1'b1; opcode = op;
      step();
      instr_valid = 1'($urandom_range(0, 1)); opcode = 6'($urandom); z = zf;
      step();
      model_exec(op, zf, e, kind);
      chk("exec", obs(), e);
      instr_valid = 1'b0;
      if (kind == 1) begin
         step();
         chk("pop2", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
         step();
         chk("post_pop2", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end else if (kind == 2) begin
         instr_valid = 1'b1; opcode = 6'b100000;
         step();
         chk("err_hold", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
         instr_valid = 1'b0; err_clr = 1'b1;
         step();
         err_clr = 1'b0;
         m_err = 1'b0;
         chk("err_clr", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   initial begin
      int kind;
      logic [5:0] rop;
      int r;

      tbl[0]  = '{6'b001100, 1'b0, 10'b1_0_1_1_0_0_1_011};
      tbl[1]  = '{6'b100000, 1'b0, 10'b1_1_1_0_0_0_1_011};
      tbl[2]  = '{6'b100001, 1'b0, 10'b0_0_0_0_0_0_1_011};
      tbl[3]  = '{6'b100010, 1'b1, 10'b0_0_0_0_0_0_1_011};
      tbl[4]  = '{6'b100010, 1'b0, 10'b1_0_0_0_0_0_1_011};
      tbl[5]  = '{6'b100011, 1'b1, 10'b1_0_0_0_0_0_1_011};
      tbl[6]  = '{6'b100011, 1'b0, 10'b0_0_0_0_0_0_1_011};
      tbl[7]  = '{6'b100110, 1'b0, 10'b1_0_0_0_0_0_1_011};
      tbl[8]  = '{6'b101001, 1'b0, 10'b1_0_0_0_0_0_1_011};
      tbl[9]  = '{6'b011111, 1'b0, 10'b1_0_1_1_0_0_1_111};
      tbl[10] = '{6'b110100, 1'b0, 10'b1_1_1_0_0_0_1_111};
      tbl[10].op = 6'b100000;

      do_reset();
      chk("reset", obs(), RESET_SNAP);

      // decode table
      for (int i = 0; i < 11; i++) begin
         instr_valid = 1'b1; opcode = tbl[i].op;
         step();
         chk("tbl_exec_idle", {8'h00, s_inm, we3, wez, push, pop, pc_en, s_pila, 3'b000}, 18'h0);
         instr_valid = 1'b0; opcode = ~tbl[i].op; z = tbl[i].zf;
         step();
         chk($sformatf("tbl%0d", i), {8'h00, s_inc, s_inm, we3, wez, push, pop, pc_en, op_alu},
             {8'h00, tbl[i].exp});
      end
      chk("tbl_sp", {15'h0, sp}, 18'h0);

      // fill to DEPTH, overflow, recover
      do_reset();
      for (int i = 0; i < DEPTH; i++) run_instr(6'b100100, 1'b0, kind);
      chk("full_sp", {14'h0, stk_full, sp}, {14'h0, 1'b1, 3'd4});
      run_instr(6'b100100, 1'b0, kind);
      chk("ovf_kind", 18'(kind), 18'd2);
      run_instr(6'b100000, 1'b0, kind);
      chk("after_clr_ldi", {15'h0, we3, s_inm, pc_en}, 18'b111);

      // call/ret, then underflow
      do_reset();
      run_instr(6'b100100, 1'b0, kind);
      run_instr(6'b100101, 1'b0, kind);
      chk("ret_empty", {14'h0, stk_empty, sp}, {14'h0, 1'b1, 3'd0});
      run_instr(6'b100101, 1'b0, kind);
      chk("unf_kind", 18'(kind), 18'd2);

      // halt is absorbing
      run_instr(6'b111111, 1'b0, kind);
      chk("halted", {17'h0, halted}, 18'h1);
      for (int i = 0; i < 20; i++) begin
         instr_valid = 1'($urandom_range(0, 1)); opcode = 6'($urandom);
         err_clr = 1'($urandom_range(0, 1)); z = 1'($urandom_range(0, 1));
         step();
         chk("halt_hold", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      do_reset();
      chk("halt_reset", obs(), RESET_SNAP);

      // async reset in POP2
      run_instr(6'b100100, 1'b0, kind);
      instr_valid = 1'b1; opcode = 6'b100101;
      step();
      instr_valid = 1'b0;
      step();
      chk("pre_abort_pop", {17'h0, pop}, 18'h1);
      #1 reset = 1'b0;
      #1 chk("abort_reset", obs(), RESET_SNAP);
      #1 reset = 1'b1;
      model_reset();
      step();
      chk("abort_idle", obs(), RESET_SNAP);

      // random stream against the model
      do_reset();
      for (int i = 0; i < 150; i++) begin
         r = $urandom_range(0, 9);
         if (r < 3)      rop = 6'b100100;
         else if (r < 6) rop = 6'b100101;
         else begin
            rop = 6'($urandom_range(0, 62));
         end
         run_instr(rop, 1'($urandom_range(0, 1)), kind);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
